pattern_detector_fsm: RTL
=========================

Name: pattern_detector_fsm

Overview:
- Serial bit-pattern detector with Moore-style registered output. Successor to the fixed two-bit "01" detector.
- Pattern width is parametrised and the pattern is runtime-loadable.
- Supports overlapping and non-overlapping detection modes, bit-valid gating, and a saturating match counter.
- Sits on serial control/data lines in the basic-logic library. Default parameters reproduce the legacy "0 then 1" detection.

Parameters:
- PAT_W, 2, pattern length in bits (>=1).
- RESET_PAT, 2'b01, pattern loaded at reset; PAT_W bits; MSB is compared first.
- CNT_W, 8, width of match counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- a  in  1  serial input bit.
- valid  in  1  a is sampled only when valid=1.
- pat_load  in  1  load pat_in as the new pattern.
- pat_in  in  PAT_W  new pattern; MSB is compared first.
- overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- y  out  1  match pulse, registered.
- match_count  out  CNT_W  number of matches since reset, saturating.

Behaviour:
- Internal state:
  - pat[PAT_W-1:0], the current pattern.
  - hist[PAT_W-1:0], a shift register; each new bit enters the LSB.
  - fill, a counter 0..PAT_W that saturates at PAT_W.
  - match, a registered flag; y = match.
- Reset (async) sets: pat=RESET_PAT, hist=0, fill=0, y=0, match_count=0.
- Per rising edge, in this priority order:
  1. pat_load=1:
     - pat<=pat_in, hist<=0, fill<=0, y<=0.
     - Any valid bit in the same cycle is discarded.
     - match_count is not cleared.
  2. valid=1:
     - hist<={hist[PAT_W-2:0],a}.
     - fill<=min(fill+1,PAT_W).
     - Accepting condition: the updated fill==PAT_W and the updated hist==pat.
     - If accepting: y<=1 and match_count increments (holds at 2^CNT_W-1).
     - If accepting and overlap=0: fill<=0 instead, so the next match needs PAT_W fresh bits.
     - If accepting and overlap=1: fill stays PAT_W, so the next match can share bits with this one.
  3. valid=0: hist and fill hold; y<=0.
- Timing: y is high for exactly one cycle, the cycle after the edge that sampled the completing bit. Back-to-back matches give back-to-back y pulses.
- The overlap input is sampled on each accepting edge. Changing it between matches is legal.
- PAT_W=1: every valid bit equal to pat[0] matches in both modes.
- Reset asserted mid-pattern clears all progress immediately. No match is reported for bits received before reset.
- The state machine view is states S0..S(PAT_W) = fill, plus the match flag. No illegal states are reachable; fill values above PAT_W are impossible by construction.

Optional Feature:
- Macro: PATTERN_DETECTOR_COUNT_EN.
- Defined: the match_count register and its increment/saturation logic are present, as described in Behaviour.
- Undefined: the counter logic is compiled out and match_count is tied to 0. The port list is unchanged; y behaviour is identical.

Test Plan:
- Default parameters (PAT_W=2, RESET_PAT=01), valid=1, a=0,1,0,1,1 -> y pulses one cycle after the 2nd and the 4th bits only; match_count=2.
- PAT_W=4, load 1011, overlap=1, stream 1,0,1,1,0,1,1 -> y after bit 4 and after bit 7; match_count=2.
- Same stream with overlap=0 -> y after bit 4 only; match_count=1.
- PAT_W=4, pattern 1011, stream 1,0,(valid=0 for 3 cycles),1,1 -> single y pulse after the final 1; y stays 0 during the gap.
- Stream 1,0,1 then pat_load with a=1/valid=1 in the same cycle, pat_in=1011, then 1,0,1,1 -> the pre-load bits and the same-cycle bit are ignored; exactly one y, after the 4th post-load bit.
- CNT_W=2, 5 matches -> match_count sticks at 3. Then assert reset mid-pattern -> y=0 and match_count=0 immediately, pattern returns to RESET_PAT.

Source files
------------

// File: rtl/pattern_detector_fsm.sv
// Serial bit-pattern detector with a registered (Moore) match pulse.
// The pattern is PAT_W bits wide, loadable at runtime, and compared MSB-first
// against the most recent PAT_W valid bits. Overlapping and non-overlapping
// detection are selected per match by the overlap input.
// Optional match counter: define PATTERN_DETECTOR_COUNT_EN to build it.
// Without the macro, match_count is tied to zero.
module pattern_detector_fsm #(
  parameter int unsigned       PAT_W     = 2,
  parameter logic [PAT_W-1:0]  RESET_PAT = PAT_W'(2'b01),
  parameter int unsigned       CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a,
  input  logic             valid,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             overlap,
  output logic             y,
  output logic [CNT_W-1:0] match_count
);

  // fill is the FSM state S0..S(PAT_W): number of usable bits in hist.
  localparam int unsigned FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_EMPTY = '0;
  localparam logic [FILL_W-1:0] FILL_FULL  = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  pat_q, pat_d;
  logic [PAT_W-1:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [FILL_W-1:0] fill_inc;
  logic              match_q, match_d;
  logic              accept;

  // Next-state: pattern load beats a valid bit; a valid bit shifts in and may complete a match.
  always_comb begin
    pat_d    = pat_q;
    hist_d   = hist_q;
    fill_d   = fill_q;
    match_d  = 1'b0;
    accept   = 1'b0;
    fill_inc = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FILL_W'(1);
    if (pat_load) begin
      // Same-cycle valid bit is dropped; progress restarts from S0.
      pat_d  = pat_in;
      hist_d = '0;
      fill_d = FILL_EMPTY;
    end else if (valid) begin
      hist_d = (hist_q << 1) | PAT_W'(a);
      fill_d = fill_inc;
      accept = (fill_inc == FILL_FULL) && (hist_d == pat_q);
      if (accept) begin
        match_d = 1'b1;
        // Non-overlapping: next match must be built from PAT_W fresh bits.
        if (!overlap) begin
          fill_d = FILL_EMPTY;
        end
      end
    end
  end

  // Detector state registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat_q   <= RESET_PAT;
      hist_q  <= '0;
      fill_q  <= FILL_EMPTY;
      match_q <= 1'b0;
    end else begin
      pat_q   <= pat_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_d;
    end
  end

  assign y = match_q;

`ifdef PATTERN_DETECTOR_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating count of accepted matches; a pattern load does not clear it.
  always_comb begin
    cnt_d = cnt_q;
    if (accept && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Match counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign match_count = cnt_q;
`else
  assign match_count = '0;
`endif

endmodule
